// File: rtl/seq_ctrl.sv
// Multi-cycle fetch/decode/execute/memory/write-back sequencer for the 16-bit core.
// Optional interrupt entry state is enabled by defining SEQ_IRQ_EN.
module seq_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_ir,
    input  logic        i_z,
    input  logic        i_mem_rdy,
`ifdef SEQ_IRQ_EN
    input  logic        i_irq,
    output logic        o_irq_ack,
`endif
    output logic        o_ir_we,
    output logic        o_imm_sel,
    output logic [2:0]  o_alu_op,
    output logic        o_alu_b_sel,
    output logic        o_pc_we,
    output logic [1:0]  o_pc_sel,
    output logic        o_addr_sel,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic        o_reg_we,
    output logic        o_wd_sel,
    output logic        o_halted,
    output logic        o_bus_err
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_IRQ
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bus_err;

    logic [2:0] w_cls;
    logic       w_req;
    logic       w_timeout;
    logic       w_unused;
    state_t     w_fetch_tgt;

    assign w_cls     = i_ir[15:13];
    assign w_req     = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_timeout = w_req && !i_mem_rdy && (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_unused  = &{1'b0, i_ir[9:0]};

`ifdef SEQ_IRQ_EN
    assign w_fetch_tgt = i_irq ? S_IRQ : S_FETCH;
`else
    assign w_fetch_tgt = S_FETCH;
`endif

    // The wait counter only runs while a request is stalled, so it restarts on every entry.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_FETCH;
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            if (w_req && !i_mem_rdy)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
            case (r_state)
                S_FETCH: begin
                    if (i_mem_rdy) begin
                        r_state <= S_DECODE;
                    end else if (w_timeout) begin
                        r_state   <= S_HALT;
                        r_bus_err <= 1'b1;
                    end
                end
                S_DECODE: r_state <= S_EXEC;
                S_EXEC: begin
                    case (w_cls)
                        3'b000, 3'b001: r_state <= S_WB;
                        3'b010, 3'b011: r_state <= S_MEM;
                        3'b111:         r_state <= S_HALT;
                        default:        r_state <= w_fetch_tgt;
                    endcase
                end
                S_MEM: begin
                    if (i_mem_rdy) begin
                        r_state <= (w_cls == 3'b011) ? w_fetch_tgt : S_WB;
                    end else if (w_timeout) begin
                        r_state   <= S_HALT;
                        r_bus_err <= 1'b1;
                    end
                end
                S_WB:    r_state <= w_fetch_tgt;
                S_HALT:  r_state <= S_HALT;
                S_IRQ:   r_state <= S_FETCH;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Strobes decode from state and are forced low while reset is held.
    always_comb begin
        o_ir_we     = 1'b0;
        o_imm_sel   = 1'b0;
        o_alu_op    = 3'b000;
        o_alu_b_sel = 1'b0;
        o_pc_we     = 1'b0;
        o_pc_sel    = 2'b00;
        o_addr_sel  = 1'b0;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_reg_we    = 1'b0;
        o_wd_sel    = 1'b0;
        o_halted    = 1'b0;
`ifdef SEQ_IRQ_EN
        o_irq_ack   = 1'b0;
`endif
        if (!i_rst) begin
            case (r_state)
                S_FETCH: begin
                    o_mem_req = 1'b1;
                    if (i_mem_rdy) begin
                        o_ir_we = 1'b1;
                        o_pc_we = 1'b1;
                    end
                end
                S_EXEC: begin
                    case (w_cls)
                        3'b000: o_alu_op = i_ir[12:10];
                        3'b001: begin
                            o_alu_op    = i_ir[12:10];
                            o_alu_b_sel = 1'b1;
                            o_imm_sel   = 1'b1;
                        end
                        3'b010, 3'b011: begin
                            o_alu_b_sel = 1'b1;
                            o_imm_sel   = 1'b1;
                        end
                        3'b100: begin
                            if (!i_ir[12] || i_z) begin
                                o_pc_we  = 1'b1;
                                o_pc_sel = 2'b01;
                            end
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    o_mem_req   = 1'b1;
                    o_addr_sel  = 1'b1;
                    o_alu_b_sel = 1'b1;
                    o_imm_sel   = 1'b1;
                    o_mem_we    = (w_cls == 3'b011);
                end
                S_WB: begin
                    o_reg_we = 1'b1;
                    o_wd_sel = (w_cls == 3'b010);
                end
                S_HALT: o_halted = 1'b1;
                S_IRQ: begin
                    o_pc_we  = 1'b1;
                    o_pc_sel = 2'b10;
`ifdef SEQ_IRQ_EN
                    o_irq_ack = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign o_bus_err = r_bus_err;

endmodule
